// File: rtl/video_timing_out.sv
// video_timing_out: raster timing generator and pixel transmitter for the
// stitched output frame. Counters walk sync -> back porch -> active -> front
// porch horizontally and vertically; pixels are pulled from the frame-buffer
// read FIFO and driven two clocks after the counter position that names them.
// Optional build macro: VIDEO_TPG_EN adds an 8-bar colour test pattern
// selected per frame by pattern_en.
module video_timing_out #(
    parameter int H_ACTIVE   = 2880,
    parameter int H_FP       = 88,
    parameter int H_SYNC     = 44,
    parameter int H_BP       = 148,
    parameter int V_ACTIVE   = 1080,
    parameter int V_FP       = 4,
    parameter int V_SYNC     = 5,
    parameter int V_BP       = 36,
    parameter int DATA_WIDTH = 24,
    parameter logic [DATA_WIDTH-1:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic                  pattern_en,
    output logic                  video_vsync,
    output logic                  video_href,
    output logic                  video_de,
    output logic [DATA_WIDTH-1:0] video_data,
    output logic                  frame_start,
    output logic                  underflow,
    output logic [15:0]           underflow_cnt
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST      = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_SYNC_END  = HW'(H_SYNC);
    localparam logic [HW-1:0] H_ACT_START = HW'(H_SYNC + H_BP);
    localparam logic [HW-1:0] H_ACT_END   = HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST      = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_END  = VW'(V_SYNC);
    localparam logic [VW-1:0] V_ACT_START = VW'(V_SYNC + V_BP);
    localparam logic [VW-1:0] V_ACT_END   = VW'(V_SYNC + V_BP + V_ACTIVE);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [HW-1:0]   h_cnt;
    logic [HW-1:0]   h_next;
    logic [VW-1:0]   v_cnt;
    logic [VW-1:0]   v_next;

    logic            run_c;
    logic            act_c;
    logic            starve_c;
    logic            hs_c;
    logic            vs_c;
    logic            fs_c;
    logic            tpg_c;

    logic            act_d1;
    logic            starve_d1;
    logic            hs_d1;
    logic            vs_d1;
    logic            fs_d1;
    logic [DATA_WIDTH-1:0] pix_c;

`ifdef VIDEO_TPG_EN
    localparam logic [HW-1:0] BAR_W = HW'(H_ACTIVE / 8);

    logic            tpg_mode;
    logic            tpg_d1;
    logic [HW-1:0]   x_c;
    logic [2:0]      bar_c;
    logic [2:0]      bar_d1;

    // Colour of each vertical bar, left to right.
    function automatic logic [DATA_WIDTH-1:0] bar_color(input logic [2:0] idx);
        logic [DATA_WIDTH-1:0] c;
        case (idx)
            3'd0:    c = DATA_WIDTH'(24'hFFFFFF);
            3'd1:    c = DATA_WIDTH'(24'hFFFF00);
            3'd2:    c = DATA_WIDTH'(24'h00FFFF);
            3'd3:    c = DATA_WIDTH'(24'h00FF00);
            3'd4:    c = DATA_WIDTH'(24'hFF00FF);
            3'd5:    c = DATA_WIDTH'(24'hFF0000);
            3'd6:    c = DATA_WIDTH'(24'h0000FF);
            default: c = DATA_WIDTH'(24'h000000);
        endcase
        return c;
    endfunction

    // Latch the pattern select at the first counter position of each frame
    // (counters sit there throughout IDLE) so a frame never mixes sources.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpg_mode <= 1'b0;
        end else if ((h_cnt == '0) && (v_cnt == '0)) begin
            tpg_mode <= pattern_en;
        end else begin
            tpg_mode <= tpg_mode;
        end
    end

    assign tpg_c = tpg_mode;
    assign x_c   = h_cnt - H_ACT_START;
    assign bar_c = 3'(x_c / BAR_W);

    // Stage-1 copy of the pattern selection and bar index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tpg_d1 <= 1'b0;
            bar_d1 <= 3'd0;
        end else begin
            tpg_d1 <= tpg_c;
            bar_d1 <= bar_c;
        end
    end
`else
    logic tpg_unused;
    assign tpg_unused = pattern_en;
    assign tpg_c      = 1'b0;
`endif

    // State and raster counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            state <= state_next;
            h_cnt <= h_next;
            v_cnt <= v_next;
        end
    end

    // Next state and counter advance; a running frame always completes
    // before the run request is re-examined.
    always_comb begin
        state_next = state;
        h_next     = h_cnt;
        v_next     = v_cnt;
        case (state)
            IDLE: begin
                h_next = '0;
                v_next = '0;
                if (en) begin
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (h_cnt == H_LAST) begin
                    h_next = '0;
                    if (v_cnt == V_LAST) begin
                        v_next = '0;
                        if (!en) begin
                            state_next = IDLE;
                        end else begin
                            state_next = RUN;
                        end
                    end else begin
                        v_next = v_cnt + VW'(1);
                    end
                end else begin
                    h_next = h_cnt + HW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                h_next     = '0;
                v_next     = '0;
            end
        endcase
    end

    // Stage 0 decode from the counter registers. Sync strobes are gated by
    // RUN so the pins stay quiet while idle with counters parked at zero.
    assign run_c      = (state == RUN);
    assign act_c      = run_c
                        && (h_cnt >= H_ACT_START) && (h_cnt < H_ACT_END)
                        && (v_cnt >= V_ACT_START) && (v_cnt < V_ACT_END);
    assign hs_c       = run_c && (h_cnt < H_SYNC_END);
    assign vs_c       = run_c && (v_cnt < V_SYNC_END);
    assign fs_c       = run_c && (h_cnt == '0) && (v_cnt == '0);
    assign starve_c   = act_c && fifo_empty && !tpg_c;
    assign fifo_rd_en = act_c && !fifo_empty && !tpg_c;

    // Stage 1: align timing with the FIFO word that returns one clock later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_d1    <= 1'b0;
            starve_d1 <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            fs_d1     <= 1'b0;
        end else begin
            act_d1    <= act_c;
            starve_d1 <= starve_c;
            hs_d1     <= hs_c;
            vs_d1     <= vs_c;
            fs_d1     <= fs_c;
        end
    end

    // Pixel source select for the output register.
    always_comb begin
        pix_c = '0;
        if (starve_d1) begin
            pix_c = UNDERFLOW_COLOR;
        end else if (act_d1) begin
`ifdef VIDEO_TPG_EN
            if (tpg_d1) begin
                pix_c = bar_color(bar_d1);
            end else begin
                pix_c = fifo_rd_data;
            end
`else
            pix_c = fifo_rd_data;
`endif
        end else begin
            pix_c = '0;
        end
    end

    // Stage 2: registered output pins, all two clocks behind the counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            video_de    <= 1'b0;
            video_data  <= '0;
            video_href  <= 1'b0;
            video_vsync <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            video_de    <= act_d1;
            video_data  <= pix_c;
            video_href  <= hs_d1;
            video_vsync <= vs_d1;
            frame_start <= fs_d1;
        end
    end

    // Sticky underflow flag and saturating starved-pixel count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            underflow     <= 1'b0;
            underflow_cnt <= 16'h0000;
        end else if (starve_c) begin
            underflow <= 1'b1;
            if (underflow_cnt != 16'hFFFF) begin
                underflow_cnt <= underflow_cnt + 16'h0001;
            end else begin
                underflow_cnt <= underflow_cnt;
            end
        end else begin
            underflow     <= underflow;
            underflow_cnt <= underflow_cnt;
        end
    end

endmodule

// File: tb/tb_video_timing_out.sv
// Testbench for video_timing_out with a reduced 14x7 raster. A per-cycle
// scoreboard holds the expected pin values computed from the raster position
// and the FIFO word sequence; entries are popped two clocks later when the
// DUT presents them.
module tb_video_timing_out;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 2;
    localparam int HB = 2;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int FT = HT * VT;
    localparam logic [23:0] UF_COLOR = 24'hFF00FF;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        fifo_rd_en;
    logic [23:0] fifo_rd_data = 24'h000000;
    logic        fifo_empty;
    logic        pattern_en;
    logic        video_vsync;
    logic        video_href;
    logic        video_de;
    logic [23:0] video_data;
    logic        frame_start;
    logic        underflow;
    logic [15:0] underflow_cnt;

    typedef struct packed {
        logic        de;
        logic [23:0] data;
        logic        hs;
        logic        vs;
        logic        fs;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tb_word = 1;
    int   word_exp = 1;
    int   rd_cnt = 0;
    bit   m_run = 1'b0;
    int   m_k = 0;
    logic m_tpg = 1'b0;

    video_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .DATA_WIDTH(24), .UNDERFLOW_COLOR(24'hFF00FF)
    ) dut (
        .clk(clk), .rst(rst), .en(en),
        .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
        .fifo_empty(fifo_empty), .pattern_en(pattern_en),
        .video_vsync(video_vsync), .video_href(video_href),
        .video_de(video_de), .video_data(video_data),
        .frame_start(frame_start), .underflow(underflow),
        .underflow_cnt(underflow_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: a read strobe returns the next sequential word one clock later.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_rd_data <= tb_word[23:0];
            tb_word      <= tb_word + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, want);
        end
    endtask

    function automatic logic [23:0] bar_exp(input int idx);
        logic [23:0] tbl [0:7];
        tbl[0] = 24'hFFFFFF; tbl[1] = 24'hFFFF00; tbl[2] = 24'h00FFFF; tbl[3] = 24'h00FF00;
        tbl[4] = 24'hFF00FF; tbl[5] = 24'hFF0000; tbl[6] = 24'h0000FF; tbl[7] = 24'h000000;
        return tbl[idx];
    endfunction

    task automatic sb_clear();
        exp_t z;
        z = '0;
        sb_q = {};
        sb_q.push_back(z);
        sb_q.push_back(z);
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic step(input logic empty_v);
        exp_t e;
        exp_t g;
        int   h;
        int   v;
        logic act;
        logic rd_want;
        fifo_empty = empty_v;
        #1;
        h   = m_k % HT;
        v   = (m_k / HT) % VT;
        act = m_run && (h >= HS + HB) && (h < HS + HB + HA) && (v >= VS + VB) && (v < VS + VB + VA);
        e   = '0;
        if (m_run) begin
            e.hs = (h < HS);
            e.vs = (v < VS);
            e.fs = (h == 0) && (v == 0);
        end
        e.de    = act;
        rd_want = act && !empty_v && !m_tpg;
        if (act) begin
            if (m_tpg) begin
                e.data = bar_exp((h - HS - HB) / (HA / 8));
            end else if (empty_v) begin
                e.data = UF_COLOR;
            end else begin
                e.data = word_exp[23:0];
                word_exp++;
            end
        end
        check_val("rd_en", {31'd0, fifo_rd_en}, {31'd0, rd_want});
        if (fifo_rd_en) rd_cnt++;
        sb_q.push_back(e);
        g = sb_q.pop_front();
        check_val("de",    {31'd0, video_de},    {31'd0, g.de});
        check_val("data",  {8'd0, video_data},   {8'd0, g.data});
        check_val("href",  {31'd0, video_href},  {31'd0, g.hs});
        check_val("vsync", {31'd0, video_vsync}, {31'd0, g.vs});
        check_val("fs",    {31'd0, frame_start}, {31'd0, g.fs});
        @(posedge clk);
`ifdef VIDEO_TPG_EN
        if (!m_run || (m_k % FT == 0)) m_tpg = pattern_en;
`endif
        if (!m_run) begin
            if (en) begin
                m_run = 1'b1;
                m_k   = 0;
            end
        end else begin
            if ((m_k % FT == FT - 1) && !en) m_run = 1'b0;
            m_k = m_k + 1;
        end
        @(negedge clk);
    endtask

    initial begin
        int h;
        int v;
        rst        = 1'b1;
        en         = 1'b0;
        fifo_empty = 1'b0;
        pattern_en = 1'b0;
        sb_clear();
        #12;
        check_val("rst_de",    {31'd0, video_de},    32'd0);
        check_val("rst_data",  {8'd0, video_data},   32'd0);
        check_val("rst_vsync", {31'd0, video_vsync}, 32'd0);
        check_val("rst_href",  {31'd0, video_href},  32'd0);
        check_val("rst_fs",    {31'd0, frame_start}, 32'd0);
        check_val("rst_rd",    {31'd0, fifo_rd_en},  32'd0);
        check_val("rst_uf",    {31'd0, underflow},   32'd0);
        check_val("rst_ufcnt", {16'd0, underflow_cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) step(1'b0);

        // Nominal frame, then two more free-running frames.
        en     = 1'b1;
        rd_cnt = 0;
        repeat (1 + FT) step(1'b0);
        check_val("frame1_reads", rd_cnt, 32'd32);
        repeat (2 * FT) step(1'b0);
        check_val("nominal_uf", {31'd0, underflow}, 32'd0);

        // Starve pixels 3 and 4 of the first active line.
        for (int i = 0; i < FT; i++) begin
            h = m_k % HT;
            v = (m_k / HT) % VT;
            step((v == VS + VB) && ((h == HS + HB + 3) || (h == HS + HB + 4)));
        end
        check_val("uf_flag", {31'd0, underflow}, 32'd1);
        check_val("uf_cnt",  {16'd0, underflow_cnt}, 32'd2);

        // Drop en on line 3: frame completes, then IDLE.
        for (int i = 0; i < FT; i++) begin
            if (i == 3 * HT) en = 1'b0;
            step(1'b0);
        end
        rd_cnt = 0;
        repeat (20) step(1'b0);
        check_val("idle_reads", rd_cnt, 32'd0);
        en = 1'b1;
        repeat (FT) step(1'b0);

        // Asynchronous reset in the middle of an active line.
        repeat (35) step(1'b0);
        check_val("pre_rst_de", {31'd0, video_de}, 32'd1);
        rst = 1'b1;
        #1;
        check_val("arst_de",    {31'd0, video_de},    32'd0);
        check_val("arst_data",  {8'd0, video_data},   32'd0);
        check_val("arst_href",  {31'd0, video_href},  32'd0);
        check_val("arst_vsync", {31'd0, video_vsync}, 32'd0);
        check_val("arst_rd",    {31'd0, fifo_rd_en},  32'd0);
        check_val("arst_uf",    {31'd0, underflow},   32'd0);
        check_val("arst_ufcnt", {16'd0, underflow_cnt}, 32'd0);
        m_run = 1'b0;
        m_k   = 0;
        m_tpg = 1'b0;
        sb_clear();
        @(negedge clk);
        rst = 1'b0;
        repeat (FT + 5) step(1'b0);

        // Pattern request: bars with no FIFO traffic when the TPG is built in,
        // otherwise ignored and the FIFO is read as usual.
        en = 1'b0;
        repeat (FT + 5) step(1'b0);
        pattern_en = 1'b1;
        en         = 1'b1;
        rd_cnt     = 0;
        repeat (1 + FT) step(1'b0);
`ifdef VIDEO_TPG_EN
        check_val("tpg_reads", rd_cnt, 32'd0);
`else
        check_val("tpg_reads", rd_cnt, 32'd32);
`endif
        pattern_en = 1'b0;
        repeat (FT) step(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
